// File: rtl/keypad_entry.sv
// Keypad entry collector: turns digit/clear/enter/cancel keypresses into a binary
// password or amount value handed to the ATM controller with a valid/ack handshake.
module keypad_entry #(
  parameter int MAX_PW_DIGITS  = 4,
  parameter int MAX_AMT_DIGITS = 5,
  parameter int TIMEOUT_CYC    = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        mode,
  input  logic        value_ack,
  output logic [16:0] value_out,
  output logic        value_valid,
  output logic        value_mode,
  output logic        cancel_pulse,
  output logic [2:0]  digit_count,
  output logic        entry_error
);

  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

  localparam int            TW         = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [2:0]    PW_LIMIT   = 3'(MAX_PW_DIGITS);
  localparam logic [2:0]    AMT_LIMIT  = 3'(MAX_AMT_DIGITS);

  state_t        state, state_nxt;
  logic [16:0]   acc, acc_nxt;
  logic [2:0]    cnt_nxt;
  logic          mode_lat, mode_lat_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [16:0]   value_out_nxt;
  logic          valid_nxt, vmode_nxt, cancel_nxt, error_nxt;

  logic          is_digit, is_clear, is_enter, is_cancel;
  logic          timeout_hit, enter_ok;
  logic [2:0]    limit;
  logic [16:0]   digit_ext, acc_times_ten;

  assign is_digit      = key_valid && (key_code <= 4'd9);
  assign is_clear      = key_valid && (key_code == 4'hA);
  assign is_enter      = key_valid && (key_code == 4'hB);
  assign is_cancel     = key_valid && (key_code == 4'hC);
  assign timeout_hit   = (state == COLLECT) && !key_valid && (timer == TIMER_LAST);
  assign limit         = mode_lat ? AMT_LIMIT : PW_LIMIT;
  assign digit_ext     = {13'd0, key_code};
  assign acc_times_ten = (acc << 3) + (acc << 1);
  // Passwords must be exactly full length; amounts need at least one digit.
  assign enter_ok      = is_enter && (digit_count != 3'd0) &&
                         (mode_lat || (digit_count == PW_LIMIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (is_digit) state_nxt = COLLECT;
      COLLECT: begin
        if (is_cancel || timeout_hit) state_nxt = IDLE;
        else if (enter_ok)            state_nxt = HOLD;
      end
      HOLD:    if (is_cancel || value_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    acc_nxt       = acc;
    cnt_nxt       = digit_count;
    mode_lat_nxt  = mode_lat;
    value_out_nxt = value_out;
    valid_nxt     = value_valid;
    vmode_nxt     = value_mode;
    cancel_nxt    = 1'b0;
    error_nxt     = 1'b0;
    timer_nxt     = (key_valid || state != COLLECT) ? '0 : timer + TW'(1);
    unique case (state)
      IDLE: begin
        if (is_digit) begin
          acc_nxt      = digit_ext;
          cnt_nxt      = 3'd1;
          mode_lat_nxt = mode;
        end else if (is_cancel) begin
          cancel_nxt = 1'b1;
        end
      end
      COLLECT: begin
        if (is_cancel || timeout_hit) begin
          cancel_nxt = 1'b1;
          acc_nxt    = '0;
          cnt_nxt    = 3'd0;
          timer_nxt  = '0;
        end else if (is_digit) begin
          if (digit_count < limit) begin
            acc_nxt = acc_times_ten + digit_ext;
            cnt_nxt = digit_count + 3'd1;
          end else begin
            error_nxt = 1'b1;
          end
        end else if (is_clear) begin
          acc_nxt = '0;
          cnt_nxt = 3'd0;
        end else if (is_enter) begin
          if (enter_ok) begin
            value_out_nxt = acc;
            valid_nxt     = 1'b1;
            vmode_nxt     = mode_lat;
          end else begin
            error_nxt = 1'b1;
          end
        end
      end
      HOLD: begin
        // A cancel in the same cycle as the ack still counts as undelivered.
        if (is_cancel) cancel_nxt = 1'b1;
        if (is_cancel || value_ack) begin
          valid_nxt = 1'b0;
          acc_nxt   = '0;
          cnt_nxt   = 3'd0;
        end
        if (is_digit || is_clear || is_enter) error_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc          <= '0;
      digit_count  <= 3'd0;
      mode_lat     <= 1'b0;
      timer        <= '0;
      value_out    <= '0;
      value_valid  <= 1'b0;
      value_mode   <= 1'b0;
      cancel_pulse <= 1'b0;
      entry_error  <= 1'b0;
    end else begin
      acc          <= acc_nxt;
      digit_count  <= cnt_nxt;
      mode_lat     <= mode_lat_nxt;
      timer        <= timer_nxt;
      value_out    <= value_out_nxt;
      value_valid  <= valid_nxt;
      value_mode   <= vmode_nxt;
      cancel_pulse <= cancel_nxt;
      entry_error  <= error_nxt;
    end
  end

endmodule

// File: doc/keypad_entry.md
KEYPAD_ENTRY -- requirements
Module: keypad_entry

Interface
REQ-001 Parameter: MAX_PW_DIGITS, default 4, number of digits in a password entry.
REQ-002 Parameter: MAX_AMT_DIGITS, default 5, maximum number of digits in an amount entry.
REQ-003 Parameter: TIMEOUT_CYC, default 1000, idle cycles after which a partial entry is abandoned.
REQ-004 Port: clk  in  1  single clock; all state changes on its rising edge.
REQ-005 Port: rst  in  1  asynchronous, active-high reset.
REQ-006 Port: key_valid  in  1  one-cycle strobe marking a new keypress.
REQ-007 Port: key_code  in  4  0-9 = digit, 0xA = clear, 0xB = enter, 0xC = cancel, 0xD-0xF = ignored.
REQ-008 Port: mode  in  1  0 = password entry, 1 = amount entry; sampled only on the first accepted digit.
REQ-009 Port: value_ack  in  1  consumer (atm_top) accepts value_out.
REQ-010 Port: value_out  out  17  binary value of the entered digits.
REQ-011 Port: value_valid  out  1  value_out is complete; held until acknowledged.
REQ-012 Port: value_mode  out  1  the mode that was latched for value_out.
REQ-013 Port: cancel_pulse  out  1  one-cycle cancel request to the ATM.
REQ-014 Port: digit_count  out  3  number of digits accepted in the current entry.
REQ-015 Port: entry_error  out  1  one-cycle pulse when a keypress is rejected.

Function
REQ-016 State machine states: IDLE, COLLECT, HOLD.
REQ-017 IDLE, digit keypress: load acc = digit, set digit_count = 1, latch mode, go to COLLECT.
REQ-018 IDLE, enter or clear: ignored; no error pulse.
REQ-019 IDLE, cancel: cancel_pulse asserted the next cycle; state stays IDLE.
REQ-020 COLLECT, digit with digit_count < limit: acc = acc*10 + digit; digit_count increments.
  - limit is MAX_PW_DIGITS when the latched mode is 0, MAX_AMT_DIGITS when it is 1.
REQ-021 COLLECT, digit with digit_count == limit: digit dropped; entry_error pulses; acc unchanged.
REQ-022 COLLECT, clear: acc = 0, digit_count = 0; state stays COLLECT.
REQ-023 COLLECT, enter in password mode with digit_count != MAX_PW_DIGITS: entry_error pulses; state stays COLLECT.
REQ-024 COLLECT, enter otherwise (with digit_count >= 1): value_out = acc, value_valid = 1, value_mode = latched mode; go to HOLD.
REQ-025 COLLECT, enter with digit_count == 0: entry_error pulses; state stays COLLECT.
REQ-026 COLLECT, cancel: cancel_pulse for 1 cycle, acc = 0, digit_count = 0, go to IDLE.
REQ-027 Output latency: every registered response (value_valid, cancel_pulse, entry_error) appears one cycle after the key_valid cycle.
REQ-028 Arithmetic:
  - acc is 17 bits, sufficient for 99999; no wrap is possible within the digit limits.
  - acc*10 is computed as (acc<<3) + (acc<<1).
REQ-029 Inactivity timeout:
  - A counter clears on every key_valid and counts cycles while in COLLECT.
  - When it reaches TIMEOUT_CYC-1: behave exactly as a cancel (REQ-026).
REQ-030 HOLD:
  - value_valid and value_out are held stable until value_ack is sampled high.
  - On that cycle: value_valid deasserts, acc and digit_count clear, go to IDLE.
REQ-031 HOLD, keypress:
  - Digit, clear or enter: dropped, entry_error pulses.
  - Cancel: cancel_pulse fires, value_valid drops, go to IDLE.
REQ-032 Simultaneous value_ack and cancel keypress in HOLD: cancel wins, and no value is considered delivered.
REQ-033 value_ack outside HOLD is ignored.
REQ-034 key_valid is assumed single-cycle; a held-high key_valid is treated as one keypress per cycle.

Reset
REQ-035 While rst = 1 (asynchronous assertion), the block holds:
  - state = IDLE;
  - acc = 0, value_out = 0, digit_count = 0;
  - value_valid = 0, value_mode = 0, cancel_pulse = 0, entry_error = 0;
  - timeout counter = 0.
REQ-036 Reset asserted mid-entry or in HOLD discards the entry without a cancel_pulse.
REQ-037 Normal operation resumes on the first rising clk edge after rst deasserts.

Verification
REQ-038 Password entry: mode=0, keys 1,2,3,4, enter -> value_out=1234, value_valid=1, value_mode=0 until ack; then IDLE, digit_count=0.
REQ-039 Amount overflow: mode=1, keys 9,9,9,9,9,9 -> sixth key raises entry_error; enter -> value_out=99999.
REQ-040 Short password: mode=0, keys 5,6, enter -> entry_error pulses, no value_valid; keys 7,8, enter -> value_out=5678.
REQ-041 Clear and cancel: keys 4,2, clear, 7, enter (mode=1) -> value_out=7; separately keys 3, cancel -> cancel_pulse 1 cycle, state IDLE.
REQ-042 Timeout: key 1, then no key for TIMEOUT_CYC cycles -> cancel_pulse exactly once; the next digit starts a fresh entry.
REQ-043 Reset mid-HOLD: value_valid=1, rst pulsed -> all outputs 0 immediately, no cancel_pulse.
